// File: rtl/led_code_sched_pkg.sv
// ledsched_pkg -- shared definitions for the LED blink-code scheduler.
// Contents:
//   state_t  : FSM state encoding (IDLE/ON/OFF/GAP)
//   BLINK_W  : width of the blink countdown (source index <= 7)
//   clog2    : bit width needed to hold values 0..value-1 (never less than 1)
//   max3     : largest of three integers, used to size the shared timer
package ledsched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_GAP  = 2'b11
    } state_t;

    localparam int BLINK_W = 3;

    function automatic int clog2(input longint unsigned value);
        int w;
        w = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < value) begin
                w = i + 1;
            end
        end
        // A zero-width vector is never useful, so one bit is the floor.
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_code_sched_if.sv
// led_code_sched_if -- event/LED bundle between the detectors, the
// scheduler and the LED pin.
//   i_evt     : per-source one-cycle event strobes (master -> slave)
//   o_led     : LED drive, 1 = lit
//   o_busy    : a blink code is in progress
//   o_grant   : one-hot source being served, 0 when idle
//   o_pending : latched events not yet served
interface led_code_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] i_evt;
    logic            o_led;
    logic            o_busy;
    logic [NREQ-1:0] o_grant;
    logic [NREQ-1:0] o_pending;

    modport master (output i_evt, input o_led, o_busy, o_grant, o_pending);
    modport slave  (input i_evt, output o_led, o_busy, o_grant, o_pending);
endinterface

// File: rtl/led_code_sched_rr_pick.sv
// rr_pick -- combinational round-robin picker.
// Searches the request vector starting just after the last-served index,
// wrapping cyclically, and returns the first hit.
//   i_req   : request vector
//   i_last  : index granted most recently
//   o_grant : one-hot winner (0 when nothing requested)
//   o_idx   : binary index of the winner
//   o_valid : at least one request present
module rr_pick
    import ledsched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan offsets 1..N from the last grant; offset N revisits last itself.
    always_comb begin
        o_grant = {N{1'b0}};
        o_idx   = {IW{1'b0}};
        o_valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!o_valid && i_req[IW'((int'(i_last) + i) % N)]) begin
                o_valid = 1'b1;
                o_idx   = IW'((int'(i_last) + i) % N);
            end else begin
                o_valid = o_valid;
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end else begin
            o_grant = {N{1'b0}};
        end
    end

endmodule

// File: rtl/led_code_sched.sv
// led_code_sched -- shares one LED among NREQ event sources by sending a
// blink code per served source: source k gives k+1 blinks then a dark gap.
//   i_clk, i_reset : clock and synchronous active-high reset
//   bus.i_evt      : per-source event strobes, latched as pending
//   bus.o_led      : LED drive (lit only in the ON state)
//   bus.o_busy     : code in progress
//   bus.o_grant    : one-hot source being served
//   bus.o_pending  : latched, not-yet-served events
module led_code_sched
    import ledsched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    led_code_sched_if.slave   bus
);

    localparam int TW = clog2(max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES));
    localparam int IW = clog2(NREQ);

    localparam logic [TW-1:0]      TMR_ON   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]      TMR_OFF  = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0]      TMR_GAP  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]      TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]      TMR_ZERO = TW'(0);
    localparam logic [BLINK_W-1:0] BLK_ONE  = 3'd1;
    localparam logic [BLINK_W-1:0] BLK_ZERO = 3'd0;

    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [BLINK_W-1:0]   r_blinks;
    logic [NREQ-1:0]      r_grant;
    logic [IW-1:0]        r_last;
    logic [NREQ-1:0]      r_pending;

    state_t               w_state_nxt;
    logic [TW-1:0]        w_timer_nxt;
    logic [BLINK_W-1:0]   w_blinks_nxt;
    logic [NREQ-1:0]      w_grant_nxt;
    logic [IW-1:0]        w_last_nxt;
    logic [NREQ-1:0]      w_clr;
    logic [NREQ-1:0]      w_pick_grant;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_pick_valid;

    // Picker sees only the registered pending vector, so an event arriving
    // this cycle waits for the next selection.
    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req   (r_pending),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Next-state, timer, blink-count and grant logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_blinks_nxt = r_blinks;
        w_grant_nxt  = r_grant;
        w_last_nxt   = r_last;
        w_clr        = {NREQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ST_ON;
                    w_grant_nxt  = w_pick_grant;
                    w_last_nxt   = w_pick_idx;
                    w_blinks_nxt = BLINK_W'(w_pick_idx);
                    w_clr        = w_pick_grant;
                    w_timer_nxt  = TMR_ON;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_ON: begin
                if (r_timer != TMR_ZERO) begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end else if (r_blinks == BLK_ZERO) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = TMR_GAP;
                end else begin
                    w_state_nxt = ST_OFF;
                    w_timer_nxt = TMR_OFF;
                end
            end
            ST_OFF: begin
                if (r_timer != TMR_ZERO) begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end else begin
                    w_state_nxt  = ST_ON;
                    w_timer_nxt  = TMR_ON;
                    w_blinks_nxt = r_blinks - BLK_ONE;
                end
            end
            ST_GAP: begin
                if (r_timer != TMR_ZERO) begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NREQ{1'b0}};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NREQ{1'b0}};
                w_timer_nxt = TMR_ZERO;
            end
        endcase
    end

    // State registers and pending latch; a new event beats the clear of the
    // grant issued in the same cycle, so it is never lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= TMR_ZERO;
            r_blinks  <= BLK_ZERO;
            r_grant   <= {NREQ{1'b0}};
            r_last    <= IW'(NREQ - 1);
            r_pending <= {NREQ{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_blinks  <= w_blinks_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_pending <= (r_pending & ~w_clr) | bus.i_evt;
        end
    end

    assign bus.o_led     = (r_state == ST_ON);
    assign bus.o_busy    = (r_state != ST_IDLE);
    assign bus.o_grant   = r_grant;
    assign bus.o_pending = r_pending;

endmodule

// File: tb/tb_led_code_sched.sv
// Testbench for led_code_sched with NREQ=4, ON=4, OFF=2, GAP=8.
// A monitor turns each completed code into a record that is checked
// against expectations queued when the stimulus is applied.
module tb_led_code_sched;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_code_sched_if #(.NREQ(4)) bus();

    led_code_sched #(
        .NREQ       (4),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] blinks;
        logic [7:0] len;
        logic       b2b;
    } code_t;

    code_t exp_q[$];
    code_t obs_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int inv_err  = 0;
    int led_err  = 0;

    function automatic code_t exp_code(input int k, input bit b2b);
        code_t c;
        c.grant  = 4'(1 << k);
        c.blinks = 8'(k + 1);
        c.len    = 8'((k + 1) * ON + k * OFF + GAP);
        c.b2b    = b2b;
        return c;
    endfunction

    // Monitor: invariants every cycle, LED phase model, code records.
    bit    in_code  = 1'b0;
    bit    prev_led = 1'b0;
    bit    exp_led;
    int    idle_run = 100;
    int    mon_k    = 0;
    int    mon_len  = 0;
    code_t cur;
    initial begin
        forever begin
            @(negedge clk);
            if (!$onehot0(bus.o_grant)) inv_err++;
            if ((bus.o_grant != 4'b0000) != bus.o_busy) inv_err++;
            if (bus.o_led && !bus.o_busy) inv_err++;
            if (rst) begin
                in_code  = 1'b0;
                idle_run = 100;
            end else if (bus.o_busy) begin
                if (!in_code) begin
                    in_code    = 1'b1;
                    cur.grant  = bus.o_grant;
                    cur.blinks = 8'd0;
                    cur.b2b    = (idle_run == 1);
                    mon_len    = 0;
                    prev_led   = 1'b0;
                    mon_k      = 0;
                    for (int i = 0; i < 4; i++) if (bus.o_grant[i]) mon_k = i;
                end
                if (bus.o_grant !== cur.grant) inv_err++;
                exp_led = (mon_len < (mon_k + 1) * ON + mon_k * OFF) && ((mon_len % (ON + OFF)) < ON);
                if (bus.o_led !== exp_led) led_err++;
                if (bus.o_led && !prev_led) cur.blinks = cur.blinks + 8'd1;
                prev_led = bus.o_led;
                mon_len++;
                idle_run = 0;
            end else begin
                if (in_code) begin
                    cur.len = 8'(mon_len);
                    obs_q.push_back(cur);
                    in_code = 1'b0;
                end
                idle_run++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_quiet();
        int t;
        t = 0;
        while ((bus.o_busy || bus.o_pending != 4'b0000) && t < 2000) begin
            @(negedge clk); t++;
        end
        if (t >= 2000) begin
            n_checks++;
            $display("FAIL quiet_timeout: busy=%0b pending=%b after %0d cycles, required idle", bus.o_busy, bus.o_pending, t);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] v);
        @(posedge clk); #1 bus.i_evt = v;
        @(posedge clk); #1 bus.i_evt = 4'b0000;
    endtask

    task automatic test_reset();
        bus.i_evt = 4'b0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending} !== 10'b0) $display("FAIL reset_state: got %b, required 0", {bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending});
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending} !== 10'b0) $display("FAIL reset_idle: got %b, required 0", {bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [9:0] e;
        logic led_e, busy_e;
        code_t o, x;
        int t;
        wait_quiet();
        @(posedge clk); #1 bus.i_evt = 4'b0100;
        exp_q.push_back(exp_code(2, 1'b0));
        for (int d = 0; d < 30; d++) begin
            @(negedge clk);
            led_e  = (d >= 2 && d <= 5) || (d >= 8 && d <= 11) || (d >= 14 && d <= 17);
            busy_e = (d >= 2 && d <= 25);
            e = {led_e, busy_e, (busy_e ? 4'b0100 : 4'b0000), ((d == 1) ? 4'b0100 : 4'b0000)};
            n_checks++;
            if ({bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending} !== e) $display("FAIL single_cycle%0d: {led,busy,grant,pending} got %b, required %b", d, {bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending}, e);
            else n_pass++;
            @(posedge clk); #1 bus.i_evt = 4'b0000;
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL single_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL single_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        code_t o, x;
        int t;
        do_reset();
        repeat (3) @(negedge clk);
        pulse(4'b1011);
        exp_q.push_back(exp_code(0, 1'b0));
        exp_q.push_back(exp_code(1, 1'b1));
        exp_q.push_back(exp_code(3, 1'b1));
        @(negedge clk);
        n_checks++;
        if ({bus.o_busy, bus.o_pending} !== 5'b01011) $display("FAIL rr_pending: {busy,pending} got %b, required 01011", {bus.o_busy, bus.o_pending});
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL rr_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL rr_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        code_t o, x;
        int t;
        wait_quiet();
        pulse(4'b0110);
        exp_q.push_back(exp_code(1, 1'b0));
        exp_q.push_back(exp_code(2, 1'b1));
        exp_q.push_back(exp_code(1, 1'b1));
        t = 0;
        while (!(bus.o_busy && bus.o_grant == 4'b0010) && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        pulse(4'b0010);
        @(negedge clk);
        n_checks++;
        if ({bus.o_grant, bus.o_pending} !== 8'b0010_0110) $display("FAIL repend_state: {grant,pending} got %b, required 00100110", {bus.o_grant, bus.o_pending});
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL repend_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL repend_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_set_wins();
        code_t o, x;
        int t;
        do_reset();
        repeat (3) @(negedge clk);
        // Held for two cycles: the second is the cycle source 0 is granted.
        @(posedge clk); #1 bus.i_evt = 4'b0001;
        @(posedge clk);
        @(posedge clk); #1 bus.i_evt = 4'b0000;
        exp_q.push_back(exp_code(0, 1'b0));
        exp_q.push_back(exp_code(0, 1'b1));
        @(negedge clk);
        n_checks++;
        if ({bus.o_busy, bus.o_grant, bus.o_pending} !== 9'b1_0001_0001) $display("FAIL setwins_state: {busy,grant,pending} got %b, required 100010001", {bus.o_busy, bus.o_grant, bus.o_pending});
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL setwins_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL setwins_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        code_t o, x;
        int t, rises;
        bit pl;
        wait_quiet();
        pulse(4'b0100);
        t = 0; rises = 0; pl = 1'b0;
        while (rises < 2 && t < 100) begin
            @(negedge clk); t++;
            if (bus.o_led && !pl) rises++;
            pl = bus.o_led;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending} !== 10'b0) $display("FAIL midreset_outputs: got %b, required 0", {bus.o_led, bus.o_busy, bus.o_grant, bus.o_pending});
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL midreset_partial: %0d code records, required 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        repeat (3) @(negedge clk);
        pulse(4'b1000);
        exp_q.push_back(exp_code(3, 1'b0));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL midreset_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL midreset_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_storm();
        code_t o, x;
        int t;
        wait_quiet();
        // Events held 50 cycles: every bit cleared during the storm is re-set,
        // source 3 is first granted after the storm ends, so the second
        // rotation covers sources 0..2 only.
        @(posedge clk); #1 bus.i_evt = 4'b1111;
        repeat (50) @(posedge clk);
        #1 bus.i_evt = 4'b0000;
        exp_q.push_back(exp_code(0, 1'b0));
        exp_q.push_back(exp_code(1, 1'b1));
        exp_q.push_back(exp_code(2, 1'b1));
        exp_q.push_back(exp_code(3, 1'b1));
        exp_q.push_back(exp_code(0, 1'b1));
        exp_q.push_back(exp_code(1, 1'b1));
        exp_q.push_back(exp_code(2, 1'b1));
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL storm_code: no code record, required grant %b", x.grant);
            else begin
                o = obs_q.pop_front();
                if (o !== x) $display("FAIL storm_code: got g=%b n=%0d len=%0d b2b=%0b, required g=%b n=%0d len=%0d b2b=%0b", o.grant, o.blinks, o.len, o.b2b, x.grant, x.blinks, x.len, x.b2b);
                else n_pass++;
            end
        end
        wait_quiet();
        n_checks++;
        if (led_err != 0) $display("FAIL led_phase: %0d cycles with wrong LED level, required 0", led_err);
        else n_pass++;
        n_checks++;
        if (inv_err != 0) $display("FAIL grant_invariant: %0d violations, required 0", inv_err);
        else n_pass++;
    endtask

    initial begin
        bus.i_evt = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_set_wins();
        test_reset_mid();
        test_storm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_code_sched.md
# led_code_sched

Blink-code scheduler that shares one board LED among NREQ event sources. Each source raises a one-cycle event. The block latches it as pending and serves pending sources in round-robin order. Serving source k drives the LED with k+1 blinks followed by a dark gap. It sits between status/fault detectors and the LED pin, alongside the power-on slow blinker.

## Interface
- NREQ, 4: number of requesters, 2..8.
- ON_CYCLES, 12_500_000: LED-on cycles per blink, ≥1.
- OFF_CYCLES, 12_500_000: LED-off cycles between blinks, ≥1.
- GAP_CYCLES, 50_000_000: dark cycles after the last blink of a code, ≥1.
- TW, derived: timer width, clog2 of max(ON,OFF,GAP) cycles.

Ports:
- i_clk, in, 1: sole clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_evt, in, NREQ: per-source event strobe, sampled every cycle.
- o_led, out, 1: LED drive, 1 = lit.
- o_busy, out, 1: a code is being sent (state ≠ IDLE).
- o_grant, out, NREQ: one-hot index of the source being served; 0 in IDLE.
- o_pending, out, NREQ: latched, not-yet-served events.

## Operation
- Pending latch, per bit:
  - Next value is `(pending & ~clr) | i_evt`.
  - `clr` is the one-hot grant issued this cycle.
  - Set wins over clear.
  - Repeated events while pending collapse into one.
- States: IDLE, ON, OFF, GAP.
  - **IDLE:** if pending ≠ 0, select the first pending index after `last` (cyclic). Then:
    - set `last`, `grant` and `blinks_left = index`;
    - clear that pending bit;
    - load `timer = ON_CYCLES-1`;
    - go to ON.
    - Otherwise stay in IDLE.
  - **ON:** when `timer == 0`:
    - if `blinks_left == 0`, go to GAP with `timer = GAP_CYCLES-1`;
    - else go to OFF with `timer = OFF_CYCLES-1`.
    - Otherwise decrement `timer`.
  - **OFF:** when `timer == 0`, decrement `blinks_left`, go to ON with `timer = ON_CYCLES-1`. Otherwise decrement `timer`.
  - **GAP:** when `timer == 0`, go to IDLE and clear `grant`. Otherwise decrement `timer`.
- Outputs:
  - `o_led = (state == ON)`, decoded from the state register only.
  - `o_busy = (state != IDLE)`.
  - `o_grant` is registered.
- A code for source k is:
  - k+1 ON periods;
  - k OFF periods;
  - one GAP period.
- A code is never preempted; new events only update pending.
- An event for the source currently being served re-pends it. That source is served again after the other pending sources, in round-robin order.
- `blinks_left` is 3 bits wide; index ≤ 7.

## Timing
- Reset values:
  - state IDLE;
  - o_led 0, o_busy 0, o_grant 0, o_pending 0;
  - timer 0, blinks_left 0;
  - `last = NREQ-1`, so source 0 is favoured first after reset.
- Reset mid-code aborts immediately; o_led is 0 on the first cycle after reset is sampled.
- Latency from i_evt at cycle t in IDLE:
  - o_pending set at t+1;
  - grant taken at t+1 edge, so o_grant, o_busy and o_led are high at t+2.
- An event arriving in the same cycle the block is in IDLE with other pending bits is still only eligible at the next selection.
- Code length for source k: (k+1)·ON_CYCLES + k·OFF_CYCLES + GAP_CYCLES cycles of o_busy.
- Back-to-back codes:
  - IDLE lasts exactly 1 cycle between GAP end and the next ON when pending ≠ 0.
  - That idle cycle has o_busy = 0 and o_grant = 0.
- Timer never wraps; it only loads or decrements from a nonzero value.

## Structure
- Shared package `ledsched_pkg`:
  - state encoding localparams (IDLE = 2'b00, ON = 2'b01, OFF = 2'b10, GAP = 2'b11);
  - clog2 helper function.
- Sub-module `rr_pick`:
  - combinational round-robin picker;
  - inputs: request vector, last-grant index;
  - outputs: one-hot grant, index, valid.
  - Reusable by other shared-resource arbiters.
- Top module holds the pending latch, FSM, timer and blink counter.

## Test plan
Bench parameters: NREQ=4, ON=4, OFF=2, GAP=8.
1. **Single code:**
   - i_evt=4'b0100 at cycle 10.
   - o_led high at cycles 12–15, 18–21, 24–27.
   - o_busy high at cycles 12–35.
   - o_grant=4'b0100 over the same cycles; o_pending clear from cycle 12.
2. **Round-robin:**
   - i_evt=4'b1011 in one cycle.
   - Codes served in order 0, 1, 3.
   - 1 idle cycle between codes; blink counts 1, 2, 4.
3. **Re-pend during service:**
   - Event for source 1 while serving source 1; source 2 also pending.
   - Order 1, 2, 1.
4. **Set-wins collision:**
   - i_evt[0] asserted in the exact cycle source 0 is granted.
   - o_pending[0] stays 1; source 0 is served twice.
5. **Reset mid-code:**
   - i_reset pulsed during the second ON of source 2.
   - Next cycle: all outputs 0.
   - A fresh event for source 3 then yields 4 blinks.
6. **Event storm:**
   - i_evt=4'b1111 held for 50 cycles.
   - Each source served once per rotation.
   - o_led never high during an OFF or GAP period.
   - o_grant always one-hot or 0.
